// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes and ALU function codes.
// The datapath and the bench import these so every block agrees on the numbers.
package multi_cycle_control_pkg;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_OR    = 6'b010001;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010010;
    localparam logic [5:0] OP_ORI   = 6'b010011;
    localparam logic [5:0] OP_SLTI  = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic is_alu_reg(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SLT};
    endfunction

    function automatic logic is_alu_imm(input logic [5:0] op);
        return op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI};
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        return op inside {OP_SW, OP_LW};
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_BLTZ};
    endfunction

endpackage

// File: rtl/mcc_decode.sv
// Combinational control-word decoder: Moore in the FSM state, qualified by opcode and ALU flags.
// The active input forces every write/load enable low while the controller is held in reset.
module mcc_decode
    import multi_cycle_control_pkg::*;
(
    input  logic [2:0] state_code,
    input  logic       active,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ExtSel,
    output logic [1:0] RegDst,
    output logic       RegWre,
    output logic       WrRegDSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc
);

    state_t st;
    logic   taken;
    logic   ends_in_id;

    assign st    = state_t'(state_code);
    assign taken = (opcode == OP_BEQ  &&  zero) ||
                   (opcode == OP_BNE  && !zero) ||
                   (opcode == OP_BLTZ &&  sign);
    // Jumps and unrecognised opcodes retire in decode; halt parks there instead.
    assign ends_in_id = !(is_alu_reg(opcode) || is_alu_imm(opcode) || is_mem(opcode) ||
                          is_branch(opcode) || opcode == OP_HALT);

    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegDst    = 2'b00;
        RegWre    = 1'b0;
        WrRegDSrc = 1'b1;
        PCSrc     = 2'b00;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        ExtSel    = !(opcode == OP_ANDI || opcode == OP_ORI);
        ALUSrcA   = (opcode == OP_SLL);
        ALUSrcB   = is_alu_imm(opcode) || is_mem(opcode);

        case (opcode)
            OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: ALUOp = ALU_SUB;
            OP_SLL:                          ALUOp = ALU_SLL;
            OP_OR, OP_ORI:                   ALUOp = ALU_OR;
            OP_AND, OP_ANDI:                 ALUOp = ALU_AND;
            OP_SLT, OP_SLTI:                 ALUOp = ALU_SLT;
            default:                         ALUOp = ALU_ADD;
        endcase

        case (st)
            S_IF: begin
                IRWre    = 1'b1;
                InsMemRW = 1'b1;
            end
            S_ID: begin
                PCWre = ends_in_id;
                if (opcode == OP_J || opcode == OP_JAL) PCSrc = 2'b11;
                else if (opcode == OP_JR)               PCSrc = 2'b10;
                if (opcode == OP_JAL) begin
                    RegWre    = 1'b1;
                    RegDst    = 2'b00;
                    WrRegDSrc = 1'b0;
                end
            end
            S_MEM: begin
                mWR       = (opcode == OP_SW);
                mRD       = (opcode == OP_LW);
                PCWre     = (opcode == OP_SW);
                DBDataSrc = (opcode == OP_LW);
            end
            S_WB_LD: begin
                PCWre     = 1'b1;
                RegWre    = 1'b1;
                RegDst    = 2'b01;
                DBDataSrc = 1'b1;
            end
            S_EXE_BR: begin
                PCWre = 1'b1;
                if (taken) PCSrc = 2'b01;
            end
            S_WB_AL: begin
                PCWre  = 1'b1;
                RegWre = 1'b1;
                RegDst = is_alu_reg(opcode) ? 2'b10 : 2'b01;
            end
            default: ;
        endcase

        if (!active) begin
            PCWre  = 1'b0;
            IRWre  = 1'b0;
            RegWre = 1'b0;
            mWR    = 1'b0;
            mRD    = 1'b0;
        end
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control unit: holds the FSM state register and next-state logic,
// and hands the current state to mcc_decode for the control word.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ExtSel,
    output logic [1:0] RegDst,
    output logic       RegWre,
    output logic       WrRegDSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc,
    output logic [2:0] state
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (is_alu_reg(opcode) || is_alu_imm(opcode)) state_d = S_EXE_AL;
                else if (is_mem(opcode))                      state_d = S_EXE_LS;
                else if (is_branch(opcode))                   state_d = S_EXE_BR;
                else if (opcode == OP_HALT)                   state_d = S_ID;
                else                                          state_d = S_IF;
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = (opcode == OP_LW) ? S_WB_LD : S_IF;
            default:  state_d = S_IF;
        endcase
    end

    assign state = state_q;

    mcc_decode u_decode (
        .state_code (state_q),
        .active     (Reset),
        .opcode     (opcode),
        .zero       (zero),
        .sign       (sign),
        .PCWre      (PCWre),
        .IRWre      (IRWre),
        .InsMemRW   (InsMemRW),
        .ExtSel     (ExtSel),
        .RegDst     (RegDst),
        .RegWre     (RegWre),
        .WrRegDSrc  (WrRegDSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSrc      (PCSrc),
        .mRD        (mRD),
        .mWR        (mWR),
        .DBDataSrc  (DBDataSrc)
    );

endmodule
